// File: rtl/cpu_defs_pkg.sv
// Shared types and widths for the multiply/divide sequencer.
package cpu_defs_pkg;

  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } md_state_t;

  typedef enum logic {
    OP_MULT,
    OP_DIV
  } md_op_t;

endpackage

// File: rtl/md_step.sv
// One MSB-first iteration of unsigned shift-add multiply or restoring divide.
module md_step
  import cpu_defs_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  md_op_t             op,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mag_b,
  input  logic               bit_in,
  output logic [2*WIDTH-1:0] acc_nxt_c,
  output logic               q_bit_c
);

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;

  // Divide keeps the partial remainder in the low WIDTH bits of acc.
  always_comb begin
    acc_nxt_c = '0;
    q_bit_c   = 1'b0;
    trial     = {acc[WIDTH-1:0], bit_in};
    diff      = trial[WIDTH-1:0] - mag_b;
    if (op == OP_MULT) begin
      acc_nxt_c = {acc[2*WIDTH-2:0], 1'b0} + {{WIDTH{1'b0}}, (bit_in ? mag_b : {WIDTH{1'b0}})};
    end else if (trial >= {1'b0, mag_b}) begin
      q_bit_c   = 1'b1;
      acc_nxt_c = {{WIDTH{1'b0}}, diff};
    end else begin
      acc_nxt_c = {{WIDTH{1'b0}}, trial[WIDTH-1:0]};
    end
  end

endmodule

// File: rtl/mult_div_seq.sv
// Multicycle signed multiply/divide sequencer holding HI/LO.
module mult_div_seq
  import cpu_defs_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  md_state_t          state_q, state_d;
  md_op_t             op_q, op_d;
  logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic [WIDTH-1:0]   opr_q, opr_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [2*WIDTH-1:0] step_acc_c;
  logic               step_q_bit_c;
  logic               accept_c;
  logic [2*WIDTH-1:0] prod_fix_c;
  logic [WIDTH-1:0]   quot_fix_c, rem_fix_c;

  md_step #(.WIDTH(WIDTH)) u_step (
    .op        (op_q),
    .acc       (acc_q),
    .mag_b     (mag_b_q),
    .bit_in    (opr_q[WIDTH-1]),
    .acc_nxt_c (step_acc_c),
    .q_bit_c   (step_q_bit_c)
  );

  assign accept_c   = ((state_q == IDLE) || (state_q == DONE)) && (start_mult || start_div);
  assign prod_fix_c = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
  assign quot_fix_c = (sign_a_q ^ sign_b_q) ? -opr_q : opr_q;
  assign rem_fix_c  = sign_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    cnt_d      = cnt_q;
    mag_b_d    = mag_b_q;
    opr_d      = opr_q;
    acc_d      = acc_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept_c) begin
          op_d       = start_mult ? OP_MULT : OP_DIV;
          sign_a_d   = op_a[WIDTH-1];
          sign_b_d   = op_b[WIDTH-1];
          opr_d      = op_a[WIDTH-1] ? -op_a : op_a;
          mag_b_d    = op_b[WIDTH-1] ? -op_b : op_b;
          acc_d      = '0;
          cnt_d      = '0;
          div_zero_d = 1'b0;
          // Divide by zero skips the iterations and leaves hi/lo untouched.
          if (!start_mult && (op_b == '0)) begin
            div_zero_d = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = RUN;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = step_acc_c;
        opr_d = {opr_q[WIDTH-2:0], (op_q == OP_DIV) ? step_q_bit_c : 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (op_q == OP_MULT) begin
          hi_d = prod_fix_c[2*WIDTH-1:WIDTH];
          lo_d = prod_fix_c[WIDTH-1:0];
        end else begin
          hi_d = rem_fix_c;
          lo_d = quot_fix_c;
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      op_q       <= OP_MULT;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      cnt_q      <= '0;
      mag_b_q    <= '0;
      opr_q      <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      cnt_q      <= cnt_d;
      mag_b_q    <= mag_b_d;
      opr_q      <= opr_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq: latency, signed results, div-by-zero, start rules, reset abort.
module tb_mult_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult, start_div;
  logic [31:0] op_a, op_b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;
  int busy_ok;

  mult_div_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present a start during cycle 0; returns sampled in cycle 1 with operands scrambled.
  task automatic launch(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start_mult = m;
    start_div  = d;
    op_a       = a;
    op_b       = b;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a       = 32'hDEAD_BEEF;
    op_b       = 32'h0000_0001;
    cyc        = 1;
  endtask

  task automatic wait_done();
    busy_ok = 1;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy !== 1'b1) busy_ok = 0;
      tick();
    end
  endtask

  task automatic run_op(input string tag, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int exp_lat, input logic exp_dz);
    launch(m, d, a, b);
    if (exp_lat > 1) chk({tag, "_busy_c1"}, 32'(busy), 32'd1);
    wait_done();
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_div_zero"}, 32'(div_zero), 32'(exp_dz));
  endtask

  initial begin
    int seen_done;
    reset      = 1'b0;
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a       = '0;
    op_b       = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    run_op("mul_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34, 1'b0);
    tick();
    chk("mul_7_m3_done_pulse", 32'(done), 32'd0);
    tick();

    run_op("div_5_0", 1'b0, 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1, 1'b1);
    run_op("mul_min_min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 34, 1'b0);
    run_op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 1'b0);
    run_op("div_min_m1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34, 1'b0);
    run_op("div_7_m2", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 34, 1'b0);
    run_op("div_100_7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 34, 1'b0);
    run_op("mul_m1_m1", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 34, 1'b0);

    repeat (5) tick();
    chk("hold_hi", hi, 32'd0);
    chk("hold_lo", lo, 32'd1);

    // Both starts together, then a divide-by-zero start during RUN that must be ignored.
    launch(1'b1, 1'b1, 32'd3, 32'd4);
    repeat (4) tick();
    @(negedge clk);
    start_div = 1'b1;
    op_a      = 32'd100;
    op_b      = 32'd0;
    tick();
    start_div = 1'b0;
    chk("ign_busy", 32'(busy), 32'd1);
    chk("ign_dz", 32'(div_zero), 32'd0);
    wait_done();
    chk("both_latency", 32'(cyc), 32'd34);
    chk("both_busy_run", 32'(busy_ok), 32'd1);
    chk("both_hi", hi, 32'd0);
    chk("both_lo", lo, 32'h0000_000C);
    chk("both_dz", 32'(div_zero), 32'd0);

    // Back-to-back from DONE, then reset abort at RUN cycle 10.
    launch(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done", 32'(done), 32'd0);
    while (cyc < 10) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset     = 1'b1;
    seen_done = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) seen_done = 1;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    chk("abort_idle_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
